// File: rtl/sdp_pipe_impl.sv
// SDP datapath, three-stage pipeline: op-select, multiply, output register.
// Result and its valid tag appear three non-held edges after the operands.
module sdp_pipe_impl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             in_valid,
    input  logic             ctl_1,
    input  logic             ctl_2,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    typedef struct packed {
        logic [WIDTH-1:0] r0;
        logic [WIDTH-1:0] c1;
        logic             v1;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic             v2;
    } s2_t;

    s1_t              s1;
    s2_t              s2;
    logic [WIDTH-1:0] op_res;

    always_comb begin
        op_res = '0;
        unique case ({ctl_1, ctl_2})
            2'b00: op_res = a + b;
            2'b01: op_res = a - b;
            2'b10: op_res = a & b;
            2'b11: op_res = a ^ b;
            default: op_res = '0;
        endcase
    end

    // Data loads regardless of in_valid; the valid bits only ride along.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= '0;
            s2        <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else if (!hold) begin
            s1.r0     <= op_res;
            s1.c1     <= c;
            s1.v1     <= in_valid;
            s2.p      <= s1.r0 * s1.c1;
            s2.v2     <= s1.v1;
            out       <= s2.p;
            out_valid <= s2.v2;
        end
    end

endmodule

// File: tb/tb_sdp_pipe_impl.sv
// Directed bench for sdp_pipe_impl: vector table plus stall/reset sequences.
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_sdp_pipe_impl;

    logic       clk = 1'b0;
    logic       reset;
    logic       hold;
    logic       in_valid;
    logic       ctl_1;
    logic       ctl_2;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] out;
    logic       out_valid;

    int checks   = 0;
    int failures = 0;

    sdp_pipe_impl #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold),
        .in_valid  (in_valid),
        .ctl_1     (ctl_1),
        .ctl_2     (ctl_2),
        .a         (a),
        .b         (b),
        .c         (c),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] vc;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic drive(input logic h, input logic v, input logic [1:0] op,
                         input logic [7:0] ia, input logic [7:0] ib,
                         input logic [7:0] ic);
        hold     = h;
        in_valid = v;
        ctl_1    = op[1];
        ctl_2    = op[0];
        a        = ia;
        b        = ib;
        c        = ic;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'b00, 8'h05, 8'h03, 8'h02, 8'h10};
        vecs[1] = '{2'b01, 8'h03, 8'h05, 8'h01, 8'hFE};
        vecs[2] = '{2'b00, 8'h10, 8'h10, 8'h10, 8'h00};
        vecs[3] = '{2'b10, 8'hF0, 8'h3C, 8'h01, 8'h30};
        vecs[4] = '{2'b11, 8'hF0, 8'h3C, 8'h03, 8'h64};
        vecs[5] = '{2'b00, 8'h01, 8'h01, 8'h07, 8'h0E};
        vecs[6] = '{2'b01, 8'h00, 8'h01, 8'hFF, 8'h01};
        vecs[7] = '{2'b00, 8'hFF, 8'hFF, 8'h02, 8'hFC};

        reset = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
        #1;
        tick();
        tick();
        reset = 1'b0;

        // idle after reset
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_out", out, 8'h00);
            check("idle_vld", {7'd0, out_valid}, 8'h00);
        end

        // single ops, exact latency
        for (int i = 0; i < 8; i++) begin
            do_reset();
            drive(1'b0, 1'b1, vecs[i].op, vecs[i].va, vecs[i].vb, vecs[i].vc);
            tick();
            drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
            tick();
            check("vec_early_vld", {7'd0, out_valid}, 8'h00);
            tick();
            check($sformatf("vec%0d_out", i), out, vecs[i].exp);
            check($sformatf("vec%0d_vld", i), {7'd0, out_valid}, 8'h01);
            tick();
            check("vec_after_out", out, 8'h00);
            check("vec_after_vld", {7'd0, out_valid}, 8'h00);
        end

        // back-to-back stream
        do_reset();
        drive(1'b0, 1'b1, 2'b10, 8'hF0, 8'h3C, 8'h01);
        tick();
        drive(1'b0, 1'b1, 2'b11, 8'hF0, 8'h3C, 8'h03);
        tick();
        drive(1'b0, 1'b1, 2'b00, 8'h01, 8'h01, 8'h07);
        tick();
        check("b2b_0", out, 8'h30);
        drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
        tick();
        check("b2b_1", out, 8'h64);
        tick();
        check("b2b_2", out, 8'h0E);
        check("b2b_2_vld", {7'd0, out_valid}, 8'h01);
        tick();
        check("b2b_end_vld", {7'd0, out_valid}, 8'h00);

        // stall for two edges after edge 1; held operands are dropped
        do_reset();
        drive(1'b0, 1'b1, 2'b00, 8'h05, 8'h03, 8'h02);
        tick();
        drive(1'b1, 1'b1, 2'b11, 8'hAA, 8'h55, 8'h07);
        tick();
        tick();
        check("stall_e3_vld", {7'd0, out_valid}, 8'h00);
        check("stall_e3_out", out, 8'h00);
        drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
        tick();
        check("stall_e4_vld", {7'd0, out_valid}, 8'h00);
        tick();
        check("stall_e5_out", out, 8'h10);
        check("stall_e5_vld", {7'd0, out_valid}, 8'h01);
        drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
        tick();
        check("stall_keep_out", out, 8'h10);
        check("stall_keep_vld", {7'd0, out_valid}, 8'h01);
        drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_drop_out", out, 8'h00);
            check("stall_drop_vld", {7'd0, out_valid}, 8'h00);
        end

        // reset in mid-operation discards everything in flight
        do_reset();
        drive(1'b0, 1'b1, 2'b00, 8'h05, 8'h03, 8'h02);
        tick();
        drive(1'b0, 1'b1, 2'b11, 8'hF0, 8'h3C, 8'h03);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_out", out, 8'h00);
        check("rst_mid_vld", {7'd0, out_valid}, 8'h00);
        drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_mid_idle_out", out, 8'h00);
            check("rst_mid_idle_vld", {7'd0, out_valid}, 8'h00);
        end

        // reset beats hold
        drive(1'b0, 1'b1, 2'b01, 8'h03, 8'h05, 8'h01);
        tick();
        drive(1'b0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
        tick();
        tick();
        check("rsthold_pre_out", out, 8'hFE);
        drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rsthold_out", out, 8'h00);
        check("rsthold_vld", {7'd0, out_valid}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
